// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sequencer port bundle: hazard inputs from the pipeline and the
// stall/flush controls plus performance counters driven back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             id_branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_stall_o;
  logic             id_ex_flush_o;
  logic             ex_mem_stall_o;
  logic             mem_wb_flush_o;
  logic             timeout_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;
  logic [CNT_W-1:0] freeze_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
           id_branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
           ex_mem_stall_o, mem_wb_flush_o, timeout_o, lu_stall_cnt_o, freeze_cnt_o,
           flush_cnt_o
  );

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
           id_branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
           ex_mem_stall_o, mem_wb_flush_o, timeout_o, lu_stall_cnt_o, freeze_cnt_o,
           flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubble, ID branch
// flush, and memory-wait freeze with watchdog, plus saturating hazard counters.
//
//   state    | meaning
//   RUN      | normal flow; a req without same-cycle ack enters MEM_WAIT
//   MEM_WAIT | data access outstanding; pipeline frozen until ack
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int          CNT_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [15:0]      TIMEOUT_L = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_wait_cnt;
  logic [15:0]      w_wait_inc;
  logic             r_timeout;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_frz_cnt;
  logic [CNT_W-1:0] r_fl_cnt;

  logic w_freeze;
  logic w_lu_raw;
  logic w_lu_eff;
  logic w_br_eff;

  logic w_pc_write;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_flush;
  logic w_ex_mem_stall;
  logic w_mem_wb_flush;

  assign w_lu_raw = hz.ex_memread_i && (hz.ex_rd_i != 5'd0) &&
                    ((hz.id_use_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                     (hz.id_use_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));

  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.dmem_req_i && !hz.dmem_ack_i) begin
          w_state_nxt = MEM_WAIT;
          w_freeze    = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped req without ack is illegal; keep waiting for the ack.
        if (hz.dmem_ack_i) w_state_nxt = RUN;
        else               w_freeze    = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_lu_eff = !w_freeze && w_lu_raw;
  assign w_br_eff = !w_freeze && !w_lu_raw && hz.id_branch_taken_i;

  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (rst_i) begin
      w_pc_write = 1'b0;
    end else if (w_freeze) begin
      w_pc_write     = 1'b0;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_lu_eff) begin
      w_pc_write    = 1'b0;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_br_eff) begin
      w_if_id_flush = 1'b1;
    end
  end

  assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RUN) begin
        r_wait_cnt <= 16'd0;
      end else if (!hz.dmem_ack_i) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == TIMEOUT_L) r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lu_cnt  <= '0;
      r_frz_cnt <= '0;
      r_fl_cnt  <= '0;
    end else begin
      if (w_lu_eff && (r_lu_cnt != CNT_MAX))  r_lu_cnt  <= r_lu_cnt + 1'b1;
      if (w_freeze && (r_frz_cnt != CNT_MAX)) r_frz_cnt <= r_frz_cnt + 1'b1;
      if (w_br_eff && (r_fl_cnt != CNT_MAX))  r_fl_cnt  <= r_fl_cnt + 1'b1;
    end
  end

  assign hz.pc_write_o     = w_pc_write;
  assign hz.if_id_stall_o  = w_if_id_stall;
  assign hz.if_id_flush_o  = w_if_id_flush;
  assign hz.id_ex_stall_o  = w_id_ex_stall;
  assign hz.id_ex_flush_o  = w_id_ex_flush;
  assign hz.ex_mem_stall_o = w_ex_mem_stall;
  assign hz.mem_wb_flush_o = w_mem_wb_flush;
  assign hz.timeout_o      = r_timeout;
  assign hz.lu_stall_cnt_o = r_lu_cnt;
  assign hz.freeze_cnt_o   = r_frz_cnt;
  assign hz.flush_cnt_o    = r_fl_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; a second instance
// with 3-bit counters exercises saturation.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] P_RST  = 7'b0000000;
  localparam logic [6:0] P_NONE = 7'b1000000;
  localparam logic [6:0] P_LU   = 7'b0100100;
  localparam logic [6:0] P_BR   = 7'b1010000;
  localparam logic [6:0] P_FRZ  = 7'b0101011;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  integer n_cmp = 0;
  integer n_err = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  hs ();

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i (clk_i), .rst_i (rst_i), .hz (hz.slave)
  );
  pipeline_hazard_ctrl #(.TIMEOUT(255), .CNT_W(3)) dut_sat (
    .clk_i (clk_i), .rst_i (rst_i), .hz (hs.slave)
  );

  wire [6:0] ctrl = {hz.pc_write_o, hz.if_id_stall_o, hz.if_id_flush_o, hz.id_ex_stall_o,
                     hz.id_ex_flush_o, hz.ex_mem_stall_o, hz.mem_wb_flush_o};

  // Advance to the next falling edge, apply one cycle of inputs to both instances.
  task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                       input logic br, input logic req, input logic ack);
    @(negedge clk_i);
    rst_i = rst;
    hz.id_rs1_i = rs1; hz.id_rs2_i = rs2; hz.id_use_rs1_i = u1; hz.id_use_rs2_i = u2;
    hz.ex_memread_i = mr; hz.ex_rd_i = rd; hz.id_branch_taken_i = br;
    hz.dmem_req_i = req; hz.dmem_ack_i = ack;
    hs.id_rs1_i = rs1; hs.id_rs2_i = rs2; hs.id_use_rs1_i = u1; hs.id_use_rs2_i = u2;
    hs.ex_memread_i = mr; hs.ex_rd_i = rd; hs.id_branch_taken_i = br;
    hs.dmem_req_i = req; hs.dmem_ack_i = ack;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ctrl !== P_RST) begin n_err++; $display("FAIL reset_ctrl got %b want %b", ctrl, P_RST); end
    n_cmp++;
    if ({hz.timeout_o, hz.lu_stall_cnt_o, hz.freeze_cnt_o, hz.flush_cnt_o} !== 97'd0) begin
      n_err++; $display("FAIL reset_regs got to=%b lu=%0d fz=%0d fl=%0d want 0", hz.timeout_o,
                        hz.lu_stall_cnt_o, hz.freeze_cnt_o, hz.flush_cnt_o);
    end
    idle();
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL reset_release got %b want %b", ctrl, P_NONE); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_LU) begin n_err++; $display("FAIL lu_rs2 got %b want %b", ctrl, P_LU); end
    idle();
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL lu_release got %b want %b", ctrl, P_NONE); end
    n_cmp++;
    if (hz.lu_stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_cnt1 got %0d want 1", hz.lu_stall_cnt_o); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL lu_rd0 got %b want %b", ctrl, P_NONE); end
    drive(1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL lu_nouse got %b want %b", ctrl, P_NONE); end
    drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_LU) begin n_err++; $display("FAIL lu_rs1 got %b want %b", ctrl, P_LU); end
    drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (hz.lu_stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL lu_cnt2 got %0d want 2", hz.lu_stall_cnt_o); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_BR) begin n_err++; $display("FAIL br_alone got %b want %b", ctrl, P_BR); end
    drive(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_LU) begin n_err++; $display("FAIL br_with_lu got %b want %b", ctrl, P_LU); end
    n_cmp++;
    if (hz.flush_cnt_o !== 32'd1) begin n_err++; $display("FAIL br_cnt1 got %0d want 1", hz.flush_cnt_o); end
    idle();
    n_cmp++;
    if ({hz.flush_cnt_o, hz.lu_stall_cnt_o} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL br_lu_cnts got fl=%0d lu=%0d want fl=1 lu=1", hz.flush_cnt_o, hz.lu_stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (ctrl !== P_FRZ) begin n_err++; $display("FAIL mem_frz%0d got %b want %b", c, ctrl, P_FRZ); end
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL mem_ack got %b want %b", ctrl, P_NONE); end
    idle();
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL mem_back_run got %b want %b", ctrl, P_NONE); end
    n_cmp++;
    if ({hz.freeze_cnt_o, hz.timeout_o} !== {32'd3, 1'b0}) begin
      n_err++; $display("FAIL mem_frz_cnt got %0d to=%b want 3 to=0", hz.freeze_cnt_o, hz.timeout_o);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (ctrl !== P_NONE) begin n_err++; $display("FAIL mem_same_ack got %b want %b", ctrl, P_NONE); end
    idle();
    n_cmp++;
    if ((ctrl !== P_NONE) || (hz.freeze_cnt_o !== 32'd3)) begin
      n_err++; $display("FAIL mem_same_ack_after got %b cnt=%0d want %b cnt=3", ctrl, hz.freeze_cnt_o, P_NONE);
    end
  endtask

  task automatic test_freeze_priority();
    do_reset();
    drive(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ctrl !== P_FRZ) begin n_err++; $display("FAIL prio_run got %b want %b", ctrl, P_FRZ); end
    drive(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ctrl !== P_FRZ) begin n_err++; $display("FAIL prio_wait got %b want %b", ctrl, P_FRZ); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    n_cmp++;
    if ({hz.lu_stall_cnt_o, hz.flush_cnt_o, hz.freeze_cnt_o} !== {32'd0, 32'd0, 32'd2}) begin
      n_err++; $display("FAIL prio_cnts got lu=%0d fl=%0d fz=%0d want 0 0 2",
                        hz.lu_stall_cnt_o, hz.flush_cnt_o, hz.freeze_cnt_o);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (hz.timeout_o !== 1'b0) begin n_err++; $display("FAIL wd_early%0d got %b want 0", c, hz.timeout_o); end
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({hz.timeout_o, ctrl} !== {1'b1, P_FRZ}) begin
      n_err++; $display("FAIL wd_fire got to=%b ctrl=%b want to=1 ctrl=%b", hz.timeout_o, ctrl, P_FRZ);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    n_cmp++;
    if ({hz.timeout_o, ctrl} !== {1'b1, P_NONE}) begin
      n_err++; $display("FAIL wd_sticky got to=%b ctrl=%b want to=1 ctrl=%b", hz.timeout_o, ctrl, P_NONE);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    n_cmp++;
    if (ctrl !== P_RST) begin n_err++; $display("FAIL wd_rst_ctrl got %b want %b", ctrl, P_RST); end
    idle();
    n_cmp++;
    if ({hz.timeout_o, hz.freeze_cnt_o, ctrl} !== {1'b0, 32'd0, P_NONE}) begin
      n_err++; $display("FAIL wd_rst_clear got to=%b fz=%0d ctrl=%b want to=0 fz=0 ctrl=%b",
                        hz.timeout_o, hz.freeze_cnt_o, ctrl, P_NONE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    end
    idle();
    n_cmp++;
    if (hs.lu_stall_cnt_o !== 3'd7) begin n_err++; $display("FAIL sat_lu3 got %0d want 7", hs.lu_stall_cnt_o); end
    n_cmp++;
    if (hz.lu_stall_cnt_o !== 32'd10) begin n_err++; $display("FAIL sat_lu32 got %0d want 10", hz.lu_stall_cnt_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (ctrl !== P_BR) begin n_err++; $display("FAIL b2b_br got %b want %b", ctrl, P_BR); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (ctrl !== P_FRZ) begin n_err++; $display("FAIL b2b_frz got %b want %b", ctrl, P_FRZ); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    n_cmp++;
    if ({hz.lu_stall_cnt_o, hz.flush_cnt_o, hz.freeze_cnt_o} !== {32'd1, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL b2b_cnts got lu=%0d fl=%0d fz=%0d want 1 1 1",
                        hz.lu_stall_cnt_o, hz.flush_cnt_o, hz.freeze_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_priority();
    test_watchdog();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
